// File: rtl/vend_purchase_ctrl.sv
// Customer-side vending purchase controller: coin credit, multi-quantity
// selection check, dispense/stock/change handshakes and owner bank.
module vend_purchase_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int CNT_W   = 4,
  parameter int PRICE_W = 4,
  parameter int MONEY_W = 8,
  parameter int BANK_W  = 12,
  localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       coin_valid,
  input  logic [MONEY_W-1:0]         coin_value,
  input  logic                       sel_valid,
  input  logic [IDX_W-1:0]           sel_index,
  input  logic [CNT_W-1:0]           sel_qty,
  input  logic                       cancel,
  input  logic [N_ITEMS*CNT_W-1:0]   all_number,
  input  logic [N_ITEMS*PRICE_W-1:0] all_price,
  output logic [MONEY_W-1:0]         credit,
  output logic                       coin_reject,
  output logic                       busy,
  output logic                       dispense_valid,
  output logic [IDX_W-1:0]           dispense_index,
  output logic [CNT_W-1:0]           dispense_qty,
  output logic                       stock_we,
  output logic [IDX_W-1:0]           stock_index,
  output logic [CNT_W-1:0]           stock_new,
  output logic                       change_valid,
  output logic [MONEY_W-1:0]         change_amount,
  output logic [BANK_W-1:0]          saved_money,
  output logic                       error,
  output logic [1:0]                 err_code
);

  localparam int TOT_W = CNT_W + PRICE_W;
  localparam int CMP_W = (TOT_W > MONEY_W) ? TOT_W : MONEY_W;
  localparam int SUM_W = ((TOT_W > BANK_W) ? TOT_W : BANK_W) + 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, DISPENSE, CHANGE, ERROR
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   qty_q;

  logic [CNT_W-1:0]   stock_arr [N_ITEMS];
  logic [PRICE_W-1:0] price_arr [N_ITEMS];
  logic               idx_ok;
  logic [CNT_W-1:0]   stock;
  logic [PRICE_W-1:0] price;
  logic [TOT_W-1:0]   total;
  logic               short_credit;
  logic [MONEY_W:0]   coin_sum;
  logic [SUM_W-1:0]   bank_sum;
  logic [BANK_W-1:0]  bank_next;

  // Unpack the stock/price buses and price the latched selection
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_arr[i] = all_number[i*CNT_W +: CNT_W];
      price_arr[i] = all_price[i*PRICE_W +: PRICE_W];
    end
    idx_ok       = 32'(idx_q) < N_ITEMS;
    stock        = idx_ok ? stock_arr[idx_q] : '0;
    price        = idx_ok ? price_arr[idx_q] : '0;
    total        = TOT_W'(qty_q) * TOT_W'(price);
    short_credit = CMP_W'(total) > CMP_W'(credit);
    coin_sum     = {1'b0, credit} + {1'b0, coin_value};
    bank_sum     = SUM_W'(saved_money) + SUM_W'(total);
    bank_next    = (bank_sum > SUM_W'({BANK_W{1'b1}}))
                 ? {BANK_W{1'b1}} : bank_sum[BANK_W-1:0];
  end

  assign busy = (state != IDLE);

  // Transaction FSM with registered pulses and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx_q          <= '0;
      qty_q          <= '0;
      credit         <= '0;
      coin_reject    <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_index <= '0;
      dispense_qty   <= '0;
      stock_we       <= 1'b0;
      stock_index    <= '0;
      stock_new      <= '0;
      change_valid   <= 1'b0;
      change_amount  <= '0;
      saved_money    <= '0;
      error          <= 1'b0;
      err_code       <= 2'd0;
    end else begin
      coin_reject    <= 1'b0;
      dispense_valid <= 1'b0;
      stock_we       <= 1'b0;
      change_valid   <= 1'b0;
      error          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mode != 2'b00) begin
            coin_reject <= coin_valid;
          end else if (cancel) begin
            coin_reject <= coin_valid;
            if (credit != '0) begin
              state         <= CHANGE;
              change_valid  <= 1'b1;
              change_amount <= credit;
              credit        <= '0;
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            idx_q       <= sel_index;
            qty_q       <= sel_qty;
            err_code    <= 2'd0;
            state       <= CHECK;
          end else if (coin_valid) begin
            if (coin_sum[MONEY_W]) coin_reject <= 1'b1;
            else credit <= coin_sum[MONEY_W-1:0];
          end
        end
        CHECK: begin
          coin_reject <= coin_valid;
          if (!idx_ok || qty_q == '0) begin
            state    <= ERROR;
            error    <= 1'b1;
            err_code <= 2'd3;
          end else if (stock < qty_q) begin
            state    <= ERROR;
            error    <= 1'b1;
            err_code <= 2'd1;
          end else if (short_credit) begin
            state    <= ERROR;
            error    <= 1'b1;
            err_code <= 2'd2;
          end else begin
            state          <= DISPENSE;
            dispense_valid <= 1'b1;
            dispense_index <= idx_q;
            dispense_qty   <= qty_q;
            stock_we       <= 1'b1;
            stock_index    <= idx_q;
            stock_new      <= stock - qty_q;
            credit         <= credit - MONEY_W'(total);
            saved_money    <= bank_next;
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (credit != '0) begin
            state         <= CHANGE;
            change_valid  <= 1'b1;
            change_amount <= credit;
            credit        <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE, ERROR: begin
          coin_reject <= coin_valid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_purchase_ctrl.sv
// Directed self-checking bench for vend_purchase_ctrl.
// A second instance with a 4-bit bank exercises bank saturation.
module tb_vend_purchase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        coin_valid = 1'b0;
  logic [7:0]  coin_value = '0;
  logic        sel_valid = 1'b0;
  logic [2:0]  sel_index = '0;
  logic [3:0]  sel_qty = '0;
  logic        cancel = 1'b0;
  logic [19:0] all_number = '0;
  logic [19:0] all_price = '0;

  logic [7:0]  credit, change_amount;
  logic        coin_reject, busy, dispense_valid, stock_we;
  logic        change_valid, error;
  logic [2:0]  dispense_index, stock_index;
  logic [3:0]  dispense_qty, stock_new;
  logic [11:0] saved_money;
  logic [1:0]  err_code;

  logic [7:0]  b_credit, b_change_amount;
  logic        b_coin_reject, b_busy, b_dispense_valid, b_stock_we;
  logic        b_change_valid, b_error;
  logic [2:0]  b_dispense_index, b_stock_index;
  logic [3:0]  b_dispense_qty, b_stock_new;
  logic [3:0]  b_saved_money;
  logic [1:0]  b_err_code;

  int checks = 0;
  int fails = 0;

  vend_purchase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_index(sel_index),
    .sel_qty(sel_qty), .cancel(cancel),
    .all_number(all_number), .all_price(all_price),
    .credit(credit), .coin_reject(coin_reject), .busy(busy),
    .dispense_valid(dispense_valid),
    .dispense_index(dispense_index),
    .dispense_qty(dispense_qty), .stock_we(stock_we),
    .stock_index(stock_index), .stock_new(stock_new),
    .change_valid(change_valid), .change_amount(change_amount),
    .saved_money(saved_money), .error(error), .err_code(err_code)
  );

  vend_purchase_ctrl #(.BANK_W(4)) dut_bank (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_index(sel_index),
    .sel_qty(sel_qty), .cancel(cancel),
    .all_number(all_number), .all_price(all_price),
    .credit(b_credit), .coin_reject(b_coin_reject), .busy(b_busy),
    .dispense_valid(b_dispense_valid),
    .dispense_index(b_dispense_index),
    .dispense_qty(b_dispense_qty), .stock_we(b_stock_we),
    .stock_index(b_stock_index), .stock_new(b_stock_new),
    .change_valid(b_change_valid), .change_amount(b_change_amount),
    .saved_money(b_saved_money), .error(b_error),
    .err_code(b_err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input int stk, input int prc);
    all_number[i*4 +: 4] = 4'(stk);
    all_price[i*4 +: 4]  = 4'(prc);
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_value = 8'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input int i, input int q);
    sel_valid = 1'b1;
    sel_index = 3'(i);
    sel_qty   = 4'(q);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (credit !== 8'd0) begin fails++;
      $display("FAIL rst_credit got %0d want 0", credit); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (saved_money !== 12'd0) begin fails++;
      $display("FAIL rst_saved got %0d want 0", saved_money); end
    checks++; if ({dispense_valid, stock_we, change_valid, error,
                   coin_reject} !== 5'b0) begin fails++;
      $display("FAIL rst_pulses got %b want 00000",
               {dispense_valid, stock_we, change_valid, error, coin_reject}); end
  endtask

  task automatic test_purchase();
    set_slot(2, 5, 3);
    coin(5);
    coin(5);
    checks++; if (credit !== 8'd10) begin fails++;
      $display("FAIL buy_credit got %0d want 10", credit); end
    sel(2, 3);
    checks++; if (busy !== 1'b1 || dispense_valid !== 1'b0) begin fails++;
      $display("FAIL buy_check got busy=%0b dv=%0b want 1 0",
               busy, dispense_valid); end
    tick();
    checks++; if (dispense_valid !== 1'b1 || stock_we !== 1'b1) begin fails++;
      $display("FAIL buy_dv got %0b%0b want 11", dispense_valid, stock_we); end
    checks++; if (dispense_index !== 3'd2 || dispense_qty !== 4'd3 ||
                  stock_index !== 3'd2) begin fails++;
      $display("FAIL buy_idx got %0d %0d %0d want 2 3 2",
               dispense_index, dispense_qty, stock_index); end
    checks++; if (stock_new !== 4'd2) begin fails++;
      $display("FAIL buy_stock got %0d want 2", stock_new); end
    checks++; if (saved_money !== 12'd9) begin fails++;
      $display("FAIL buy_saved got %0d want 9", saved_money); end
    tick();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd1) begin fails++;
      $display("FAIL buy_change got %0b/%0d want 1/1",
               change_valid, change_amount); end
    checks++; if (credit !== 8'd0 || dispense_valid !== 1'b0) begin fails++;
      $display("FAIL buy_after got %0d/%0b want 0/0", credit, dispense_valid); end
    tick();
    checks++; if (change_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL buy_idle got %0b/%0b want 0/0", change_valid, busy); end
  endtask

  task automatic test_last_unit();
    set_slot(1, 2, 4);
    coin(20);
    sel(1, 2);
    tick();
    checks++; if (dispense_valid !== 1'b1 || stock_new !== 4'd0) begin fails++;
      $display("FAIL last_stock got %0b/%0d want 1/0", dispense_valid, stock_new); end
    checks++; if (saved_money !== 12'd17) begin fails++;
      $display("FAIL last_saved got %0d want 17", saved_money); end
    tick();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd12) begin fails++;
      $display("FAIL last_change got %0b/%0d want 1/12",
               change_valid, change_amount); end
    tick();
    set_slot(1, 0, 4);
    coin(4);
    sel(1, 1);
    tick();
    checks++; if (error !== 1'b1 || err_code !== 2'd1) begin fails++;
      $display("FAIL oos_err got %0b/%0d want 1/1", error, err_code); end
    checks++; if (credit !== 8'd4 || dispense_valid !== 1'b0) begin fails++;
      $display("FAIL oos_credit got %0d/%0b want 4/0", credit, dispense_valid); end
    tick();
    do_cancel();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd4) begin fails++;
      $display("FAIL oos_refund got %0b/%0d want 1/4",
               change_valid, change_amount); end
    tick();
  endtask

  task automatic test_short_credit();
    set_slot(0, 5, 7);
    coin(10);
    sel(0, 2);
    checks++; if (err_code !== 2'd0) begin fails++;
      $display("FAIL short_clr got %0d want 0", err_code); end
    tick();
    checks++; if (error !== 1'b1 || err_code !== 2'd2) begin fails++;
      $display("FAIL short_err got %0b/%0d want 1/2", error, err_code); end
    checks++; if (credit !== 8'd10) begin fails++;
      $display("FAIL short_credit got %0d want 10", credit); end
    tick();
    do_cancel();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd10 ||
                  credit !== 8'd0) begin fails++;
      $display("FAIL short_refund got %0b/%0d/%0d want 1/10/0",
               change_valid, change_amount, credit); end
    tick();
  endtask

  task automatic test_bounds();
    coin(250);
    coin(10);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd250) begin fails++;
      $display("FAIL ovf_reject got %0b/%0d want 1/250", coin_reject, credit); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin fails++;
      $display("FAIL ovf_pulse got %0b want 0", coin_reject); end
    sel(6, 1);
    tick();
    checks++; if (error !== 1'b1 || err_code !== 2'd3) begin fails++;
      $display("FAIL badidx got %0b/%0d want 1/3", error, err_code); end
    tick();
    checks++; if (error !== 1'b0 || err_code !== 2'd3) begin fails++;
      $display("FAIL errhold got %0b/%0d want 0/3", error, err_code); end
    sel(0, 0);
    checks++; if (err_code !== 2'd0) begin fails++;
      $display("FAIL qty0_clr got %0d want 0", err_code); end
    tick();
    checks++; if (error !== 1'b1 || err_code !== 2'd3) begin fails++;
      $display("FAIL qty0 got %0b/%0d want 1/3", error, err_code); end
    tick();
    do_cancel();
    checks++; if (change_amount !== 8'd250 || change_valid !== 1'b1) begin fails++;
      $display("FAIL bnd_refund got %0b/%0d want 1/250",
               change_valid, change_amount); end
    tick();
  endtask

  task automatic test_priority_mode();
    coin(6);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    sel_index  = 3'd0;
    sel_qty    = 4'd1;
    coin_valid = 1'b1;
    coin_value = 8'd3;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd6) begin fails++;
      $display("FAIL prio_refund got %0b/%0d want 1/6",
               change_valid, change_amount); end
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin fails++;
      $display("FAIL prio_coin got %0b/%0d want 1/0", coin_reject, credit); end
    tick();
    checks++; if (dispense_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL prio_nodisp got %0b/%0b want 0/0", dispense_valid, busy); end
    coin(2);
    mode = 2'b01;
    coin(5);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd2) begin fails++;
      $display("FAIL mode_coin got %0b/%0d want 1/2", coin_reject, credit); end
    sel(0, 1);
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL mode_sel got %0b want 0", busy); end
    mode = 2'b00;
    do_cancel();
    checks++; if (change_amount !== 8'd2 || change_valid !== 1'b1) begin fails++;
      $display("FAIL mode_refund got %0b/%0d want 1/2",
               change_valid, change_amount); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_slot(2, 5, 3);
    coin(10);
    sel(2, 1);
    tick();
    checks++; if (dispense_valid !== 1'b1) begin fails++;
      $display("FAIL mid_disp got %0b want 1", dispense_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({dispense_valid, stock_we, busy} !== 3'b0 ||
                  credit !== 8'd0 || saved_money !== 12'd0) begin fails++;
      $display("FAIL mid_rst got %b/%0d/%0d want 000/0/0",
               {dispense_valid, stock_we, busy}, credit, saved_money); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (change_valid !== 1'b0 || credit !== 8'd0) begin fails++;
      $display("FAIL mid_nochg got %0b/%0d want 0/0", change_valid, credit); end
  endtask

  task automatic test_bank_sat();
    set_slot(0, 5, 7);
    set_slot(1, 5, 5);
    coin(14);
    sel(0, 2);
    tick();
    checks++; if (b_saved_money !== 4'd14 || saved_money !== 12'd14) begin fails++;
      $display("FAIL bank14 got %0d/%0d want 14/14", b_saved_money, saved_money); end
    tick();
    checks++; if (change_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL bank_nochg got %0b/%0b want 0/0", change_valid, busy); end
    coin(5);
    sel(1, 1);
    tick();
    checks++; if (b_saved_money !== 4'd15) begin fails++;
      $display("FAIL bank_sat got %0d want 15", b_saved_money); end
    checks++; if (saved_money !== 12'd19) begin fails++;
      $display("FAIL bank_wide got %0d want 19", saved_money); end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_purchase();
    test_last_unit();
    test_short_credit();
    test_bounds();
    test_priority_mode();
    test_reset_mid();
    test_bank_sat();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/vend_purchase_ctrl.md
Name: vend_purchase_ctrl

Overview:
Parametrised customer-side purchase controller for the vending machine, replacing the single-shot purchase logic. Accumulates coin credit, validates a multi-quantity selection against per-item stock and price, and issues dispense, stock-update and change handshakes. Keeps the owner bank (`saved_money`) in an internal register. Active only in customer mode (`mode == 2'b00`); sits between the coin/keypad front end and the stock/price register file.

Parameters:
- N_ITEMS, 5, number of item slots.
- CNT_W, 4, stock count and quantity width.
- PRICE_W, 4, unit price width.
- MONEY_W, 8, credit/coin/change width.
- BANK_W, 12, saved_money width.
- (localparam) IDX_W = max(1, clog2(N_ITEMS)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  machine mode; 2'b00 = customer.
- coin_valid  in  1  one-cycle coin strobe.
- coin_value  in  MONEY_W  value of inserted coin.
- sel_valid  in  1  one-cycle selection strobe.
- sel_index  in  IDX_W  selected item slot.
- sel_qty  in  CNT_W  requested quantity.
- cancel  in  1  refund request.
- all_number  in  N_ITEMS*CNT_W  packed stock counts; slot i at [i*CNT_W +: CNT_W].
- all_price  in  N_ITEMS*PRICE_W  packed prices; slot i at [i*PRICE_W +: PRICE_W].
- credit  out  MONEY_W  current customer credit.
- coin_reject  out  1  coin not accepted (pulse).
- busy  out  1  FSM not in IDLE.
- dispense_valid  out  1  dispense pulse.
- dispense_index  out  IDX_W  slot dispensed.
- dispense_qty  out  CNT_W  quantity dispensed.
- stock_we  out  1  stock write strobe (same cycle as dispense_valid).
- stock_index  out  IDX_W  slot to write.
- stock_new  out  CNT_W  new stock count.
- change_valid  out  1  change pulse.
- change_amount  out  MONEY_W  change paid out.
- saved_money  out  BANK_W  accumulated takings.
- error  out  1  error pulse.
- err_code  out  2  1 = out of stock, 2 = insufficient credit, 3 = bad index or qty == 0; held until the next accepted sel_valid.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs and registers = 0. Reset mid-transaction discards credit with no change pulse.
- All pulse outputs are registered and last exactly one cycle.
- Latched selection means sel_index and sel_qty captured on an accepted sel_valid.
- IDLE, with mode == 00:
  - coin_valid adds coin_value to credit. If the sum exceeds 2^MONEY_W-1, credit is unchanged and coin_reject pulses next cycle.
  - sel_valid latches sel_index and sel_qty, clears err_code, and moves to CHECK.
  - cancel with credit > 0 moves to CHANGE. cancel with credit == 0 is a no-op.
  - Same-cycle priority: cancel > sel_valid > coin. A coin coincident with sel_valid or cancel is rejected.
- IDLE, with mode != 00: coins are rejected; sel_valid and cancel are ignored; credit is retained.
- CHECK (1 cycle):
  - total = latched qty * price[idx], computed at CNT_W+PRICE_W bits, no truncation.
  - Checks in order:
    - idx >= N_ITEMS or qty == 0 → ERROR, code 3.
    - stock < qty → ERROR, code 1.
    - total > credit → ERROR, code 2.
    - otherwise → DISPENSE.
- DISPENSE (1 cycle):
  - dispense_valid = stock_we = 1; stock_new = stock - qty; outputs carry the latched idx and qty.
  - credit -= total.
  - saved_money += total, saturating at 2^BANK_W-1.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE (1 cycle): change_valid = 1, change_amount = credit, credit = 0 → IDLE.
- ERROR (1 cycle): error = 1, err_code set, credit retained → IDLE.
- Latency: sel_valid accepted at edge T gives dispense_valid/stock_we in cycle T+2 and change_valid in T+3. An error gives error in T+2.
- Outside IDLE:
  - coin_valid → coin_reject.
  - sel_valid and cancel are ignored.
  - A mode change does not abort an in-flight transaction.
- all_number and all_price are sampled in CHECK and DISPENSE; the upstream holds them stable while busy.
- Dispensing the last unit (stock == qty) writes stock_new = 0.

Test Plan:
1. Slot2 price 3, stock 5; coins 5, 5 (credit 10); sel idx2 qty3 → T+2: dispense idx2 qty3, stock_new 2, saved_money 9; T+3: change_amount 1; credit 0.
2. Slot1 price 4, stock 2; credit 20; sel qty2 → dispense, stock_new 0, saved +8, change 12. Then sel idx1 qty1 → error, err_code 1, credit unchanged.
3. Slot0 price 7; credit 10; sel qty2 (total 14) → error, err_code 2, credit stays 10. Then cancel → change_amount 10, credit 0.
4. MONEY_W = 8, credit 250, coin 10 → coin_reject, credit 250. sel idx 6 (N_ITEMS = 5) → err_code 3. sel qty 0 → err_code 3.
5. Same cycle cancel + sel_valid + coin, credit 6 → refund 6, no dispense, coin_reject. mode = 01 with coin 5 → coin_reject, credit unchanged.
6. rst_n low during DISPENSE → all outputs 0 immediately, no change pulse. Bank saturation: BANK_W = 4, saved 14, purchase total 5 → saved_money 15.
